// File: rtl/led_chaser.sv
// led_chaser: parametrised LED pattern generator (rotate, bounce, bar, hold).
// A prescaler produces a clock enable; all state lives in the clk domain.
// Optional build macro LED_PWM_EN adds a duty[3:0] input that gates the LEDs.
module led_chaser #(
    parameter int N_LED = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic [DIV_W-1:0] div_max,
    input  logic [1:0]       mode,
    input  logic             sw,
`ifdef LED_PWM_EN
    input  logic [3:0]       duty,
`endif
    output logic [N_LED-1:0] data,
    output logic             step,
    output logic             wrap
);

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_BAR    = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam int PW = $clog2(N_LED + 1);
    localparam logic [PW-1:0] POS_LAST = PW'(N_LED - 1);
    localparam logic [PW-1:0] POS_FULL = PW'(N_LED);

    mode_t            mode_in;
    mode_t            mode_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [PW-1:0]    pos;
    logic [PW-1:0]    pos_nxt;
    logic             bdir;
    logic             bdir_nxt;
    logic [N_LED-1:0] pat;
    logic [N_LED-1:0] pat_nxt;
    logic             step_nxt;
    logic             wrap_nxt;
    logic             tick;
    logic             mode_chg;

    assign mode_in  = mode_t'(mode);
    // The >= comparison lets a lowered div_max take effect on the next cycle.
    assign tick     = en && (cnt >= div_max);
    assign mode_chg = en && (mode_in != mode_q);

    // LED image for a given position: one-hot for rotate/bounce/hold,
    // a bar of p lit LEDs growing from the LSB (dir_hi=0) or MSB (dir_hi=1).
    function automatic logic [N_LED-1:0] image(mode_t m, logic [PW-1:0] p, logic dir_hi);
        logic [N_LED-1:0] img;
        img = '0;
        for (int i = 0; i < N_LED; i++) begin
            if (m == MODE_BAR)
                img[i] = dir_hi ? (i >= N_LED - int'(p)) : (i < int'(p));
            else
                img[i] = (i == int'(p));
        end
        return img;
    endfunction

    // Next-state logic: prescaler, mode-change clear (beats a tick), pattern step.
    always_comb begin
        cnt_nxt  = cnt;
        pos_nxt  = pos;
        bdir_nxt = bdir;
        pat_nxt  = pat;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;

        if (en)
            cnt_nxt = tick ? '0 : cnt + DIV_W'(1);

        if (mode_chg) begin
            pos_nxt  = '0;
            bdir_nxt = 1'b0;
            pat_nxt  = image(mode_in, '0, sw);
        end else if (tick && mode_q != MODE_HOLD) begin
            case (mode_q)
                MODE_ROTATE: begin
                    if (!sw) begin
                        if (pos >= POS_LAST) begin
                            pos_nxt  = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            pos_nxt  = POS_LAST;
                            wrap_nxt = 1'b1;
                        end else begin
                            pos_nxt = pos - PW'(1);
                        end
                    end
                end
                MODE_BOUNCE: begin
                    if (!bdir) begin
                        pos_nxt = pos + PW'(1);
                        if (pos_nxt >= POS_LAST)
                            bdir_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos - PW'(1);
                        if (pos_nxt == '0) begin
                            bdir_nxt = 1'b0;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    if (pos >= POS_FULL) begin
                        pos_nxt  = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        pos_nxt = pos + PW'(1);
                    end
                end
            endcase
            step_nxt = 1'b1;
            pat_nxt  = image(mode_q, pos_nxt, sw);
        end
    end

    // State register; mode_q only follows mode while enabled so a pause freezes everything.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt    <= '0;
            pos    <= '0;
            bdir   <= 1'b0;
            mode_q <= MODE_ROTATE;
            pat    <= N_LED'(1);
            step   <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pos    <= pos_nxt;
            bdir   <= bdir_nxt;
            if (en)
                mode_q <= mode_in;
            pat    <= pat_nxt;
            step   <= step_nxt;
            wrap   <= wrap_nxt;
        end
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_cnt;
    logic       pwm_on;

    assign pwm_on = (duty == 4'hF) || (pwm_cnt < duty);

    // Free-running PWM counter and gated output register, same latency as the pattern.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pwm_cnt <= 4'h0;
            data    <= N_LED'(1);
        end else begin
            pwm_cnt <= pwm_cnt + 4'h1;
            data    <= pat_nxt & {N_LED{pwm_on}};
        end
    end
`else
    assign data = pat;
`endif

endmodule

// File: tb/tb_led_chaser.sv
// tb_led_chaser: directed-vector scoreboard bench for led_chaser (N_LED=8).
// Build with or without LED_PWM_EN; with it the bench drives duty=4'hF.
module tb_led_chaser;

    localparam int N  = 8;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          res;
    logic          en;
    logic [DW-1:0] div_max;
    logic [1:0]    mode;
    logic          sw;
`ifdef LED_PWM_EN
    logic [3:0]    duty;
`endif
    logic [N-1:0]  data;
    logic          step;
    logic          wrap;

    typedef struct packed {
        logic [7:0] d;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    led_chaser #(.N_LED(N), .DIV_W(DW)) dut (
        .clk    (clk),
        .res    (res),
        .en     (en),
        .div_max(div_max),
        .mode   (mode),
        .sw     (sw),
`ifdef LED_PWM_EN
        .duty   (duty),
`endif
        .data   (data),
        .step   (step),
        .wrap   (wrap)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic s, input logic [DW-1:0] dm);
        en      = e;
        mode    = m;
        sw      = s;
        div_max = dm;
    endtask

    task automatic expectStep(input logic [7:0] d, input logic w);
        sb.push_back('{d: d, w: w});
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for the monitor to consume every queued update, then realign.
    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s pending_updates actual=%0d required=0", name, sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every step pulse pops one expected update and compares data and wrap.
    always @(negedge clk) begin
        exp_t e;
        if (!res) begin
            if (step) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_step actual=1 required=0 data=%0h", data);
                end else begin
                    e = sb.pop_front();
                    checkOutput("step_data", 32'(data), 32'(e.d));
                    checkOutput("step_wrap", 32'(wrap), 32'(e.w));
                end
            end else if (wrap) begin
                checkOutput("wrap_without_step", 32'(wrap), 32'd0);
            end
        end
    end

    initial begin
        res = 1'b1;
`ifdef LED_PWM_EN
        duty = 4'hF;
`endif
        applyStimulus(1'b0, 2'b00, 1'b0, '0);
        #2;
        checkOutput("reset_data", 32'(data), 32'h01);
        checkOutput("reset_step", 32'(step), 32'd0);
        checkOutput("reset_wrap", 32'(wrap), 32'd0);
        #10 res = 1'b0;
        runCycles(1);

        // Rotate up to 8'h20, then async reset mid-cycle
        expectStep(8'h02, 1'b0); expectStep(8'h04, 1'b0);
        expectStep(8'h08, 1'b0); expectStep(8'h10, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, '0);
        runCycles(5);
        checkOutput("pre_reset_data", 32'(data), 32'h20);
        checkOutput("pre_reset_step", 32'(step), 32'd1);
        #2 res = 1'b1;
        #1;
        checkOutput("async_reset_data", 32'(data), 32'h01);
        checkOutput("async_reset_step", 32'(step), 32'd0);
        checkOutput("async_reset_wrap", 32'(wrap), 32'd0);
        en = 1'b0;
        runCycles(1);
        res = 1'b0;
        drain("reset_phase");

        // Rotate toward MSB, full period plus one
        expectStep(8'h02, 1'b0); expectStep(8'h04, 1'b0); expectStep(8'h08, 1'b0);
        expectStep(8'h10, 1'b0); expectStep(8'h20, 1'b0); expectStep(8'h40, 1'b0);
        expectStep(8'h80, 1'b0); expectStep(8'h01, 1'b1); expectStep(8'h02, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, '0);
        runCycles(9);
        en = 1'b0;
        drain("rotate_up");

        // Rotate toward LSB from 8'h02
        expectStep(8'h01, 1'b0); expectStep(8'h80, 1'b1); expectStep(8'h40, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b1, '0);
        runCycles(3);
        en = 1'b0;
        drain("rotate_down");

        // Bounce, div_max=2: mode-change edge then an update every 3 cycles
        applyStimulus(1'b1, 2'b01, 1'b1, 24'd2);
        runCycles(1);
        checkOutput("bounce_clear_data", 32'(data), 32'h01);
        checkOutput("bounce_clear_step", 32'(step), 32'd0);
        expectStep(8'h02, 1'b0); expectStep(8'h04, 1'b0); expectStep(8'h08, 1'b0);
        expectStep(8'h10, 1'b0); expectStep(8'h20, 1'b0); expectStep(8'h40, 1'b0);
        expectStep(8'h80, 1'b0); expectStep(8'h40, 1'b0); expectStep(8'h20, 1'b0);
        expectStep(8'h10, 1'b0); expectStep(8'h08, 1'b0); expectStep(8'h04, 1'b0);
        expectStep(8'h02, 1'b0); expectStep(8'h01, 1'b1); expectStep(8'h02, 1'b0);
        runCycles(20);
        sw = 1'b0;
        runCycles(24);
        en = 1'b0;
        drain("bounce");

        // Bar, low fill
        applyStimulus(1'b1, 2'b10, 1'b0, '0);
        runCycles(1);
        checkOutput("bar_clear_data", 32'(data), 32'h00);
        checkOutput("bar_clear_step", 32'(step), 32'd0);
        expectStep(8'h01, 1'b0); expectStep(8'h03, 1'b0); expectStep(8'h07, 1'b0);
        expectStep(8'h0F, 1'b0); expectStep(8'h1F, 1'b0); expectStep(8'h3F, 1'b0);
        expectStep(8'h7F, 1'b0); expectStep(8'hFF, 1'b0); expectStep(8'h00, 1'b1);
        expectStep(8'h01, 1'b0);
        runCycles(10);
        en = 1'b0;
        drain("bar_low");

        // Bar, high fill continuing from pos=1
        expectStep(8'hC0, 1'b0); expectStep(8'hE0, 1'b0); expectStep(8'hF0, 1'b0);
        expectStep(8'hF8, 1'b0); expectStep(8'hFC, 1'b0); expectStep(8'hFE, 1'b0);
        expectStep(8'hFF, 1'b0); expectStep(8'h00, 1'b1); expectStep(8'h80, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b1, '0);
        runCycles(9);
        en = 1'b0;
        drain("bar_high");

        // Pause for 10 cycles mid-sweep, then resume to FF
        expectStep(8'h03, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, '0);
        runCycles(1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            runCycles(1);
            checkOutput("pause_data", 32'(data), 32'h03);
            checkOutput("pause_step", 32'(step), 32'd0);
        end
        expectStep(8'h07, 1'b0); expectStep(8'h0F, 1'b0); expectStep(8'h1F, 1'b0);
        expectStep(8'h3F, 1'b0); expectStep(8'h7F, 1'b0); expectStep(8'hFF, 1'b0);
        en = 1'b1;
        runCycles(6);
        en = 1'b0;
        drain("pause_resume");

        // Bar at FF switched to rotate: clear beats the coincident tick
        applyStimulus(1'b1, 2'b00, 1'b0, '0);
        runCycles(1);
        checkOutput("modechg_data", 32'(data), 32'h01);
        checkOutput("modechg_step", 32'(step), 32'd0);
        checkOutput("modechg_wrap", 32'(wrap), 32'd0);
        expectStep(8'h02, 1'b0); expectStep(8'h04, 1'b0);
        runCycles(2);
        en = 1'b0;
        drain("rotate_after_modechg");

        // Hold: ticks keep coming but the pattern stays put
        applyStimulus(1'b1, 2'b11, 1'b0, '0);
        runCycles(1);
        checkOutput("hold_clear_step", 32'(step), 32'd0);
        for (int i = 0; i < 5; i++) begin
            runCycles(1);
            checkOutput("hold_data", 32'(data), 32'h01);
            checkOutput("hold_step", 32'(step), 32'd0);
        end
        en = 1'b0;
        drain("hold");

        // div_max=100 until cnt=50, then drop to 3
        applyStimulus(1'b1, 2'b00, 1'b0, 24'd100);
        runCycles(50);
        en = 1'b0;
        checkOutput("slow_data", 32'(data), 32'h01);
        checkOutput("slow_step", 32'(step), 32'd0);
        runCycles(1);
        expectStep(8'h02, 1'b0); expectStep(8'h04, 1'b0); expectStep(8'h08, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 24'd3);
        runCycles(1);
        checkOutput("divdrop_first_step", 32'(step), 32'd1);
        runCycles(8);
        en = 1'b0;
        drain("divdrop");
        checkOutput("divdrop_final_data", 32'(data), 32'h08);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
